// File: rtl/instr_loader_encoder.sv
// Encodes symbolic RV32I instruction fields into 32-bit words and writes them
// into instruction memory at consecutive word addresses, one word per two cycles.
module instr_loader_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [15:0] count,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] MAX_CNT  = 16'(MAX_WORDS);
    localparam logic [6:0]  OPC_R    = 7'b0110011;
    localparam logic [6:0]  OPC_IMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD = 7'b0000011;
    localparam logic [6:0]  OPC_STR  = 7'b0100011;
    localparam logic [2:0]  OP_ILL   = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_t;

    state_t      state;
    logic        fin_pend;
    logic [31:0] enc_c;
    logic        accept_c;
    logic        last_word_c;

    assign accept_c    = in_valid & in_ready;
    assign last_word_c = ((count + 16'd1) == MAX_CNT);

    // Field-to-word encoder; unused fields of each format are dropped.
    always_comb begin
        enc_c = 32'h0;
        case (op)
            3'd0:    enc_c = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
            3'd1:    enc_c = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
            3'd2:    enc_c = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
            3'd3:    enc_c = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
            3'd4:    enc_c = {imm, rs1, 3'b000, rd, OPC_IMM};
            3'd5:    enc_c = {imm, rs1, 3'b010, rd, OPC_LOAD};
            3'd6:    enc_c = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STR};
            default: enc_c = 32'h0;
        endcase
    end

    // Session FSM with registered outputs; fin_pend remembers a finish seen before the write ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            fin_pend  <= 1'b0;
            in_ready  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'h0;
            count     <= 16'h0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        in_ready <= 1'b1;
                        mem_addr <= BASE_ADDR;
                        count    <= 16'h0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        fin_pend <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_c && (op != OP_ILL)) begin
                        mem_wdata <= enc_c;
                        mem_write <= 1'b1;
                        in_ready  <= 1'b0;
                        fin_pend  <= fin_pend | finish;
                        state     <= ST_WRITE;
                    end else begin
                        if (accept_c) begin
                            err <= 1'b1;
                        end
                        if (finish || fin_pend) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                            fin_pend <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    mem_write <= 1'b0;
                    mem_addr  <= mem_addr + 32'd4;
                    count     <= count + 16'd1;
                    if (last_word_c || fin_pend || finish) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        fin_pend <= 1'b0;
                    end else begin
                        state    <= ST_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader_encoder.sv
// Self-checking bench for instr_loader_encoder: directed scenarios plus randomized
// sessions compared against an arithmetic reference encoder and session model.
module tb_instr_loader_encoder;

    localparam int unsigned MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, finish, in_valid, in_ready;
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic        mem_write, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] count;

    int tests  = 0;
    int failed = 0;

    // Session model
    int unsigned m_count;
    logic [31:0] m_addr;
    logic        m_err;
    logic        m_done;

    instr_loader_encoder #(.BASE_ADDR(32'h0), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder built from field weights rather than bit concatenation.
    function automatic logic [31:0] ref_enc(input int unsigned o, input int unsigned d,
                                            input int unsigned s1, input int unsigned s2,
                                            input int unsigned im);
        int unsigned f3, f7, w;
        w = 0;
        if (o <= 3) begin
            f7 = (o == 1) ? 32 : 0;
            f3 = (o == 2) ? 7 : ((o == 3) ? 6 : 0);
            w  = f7 * (1 << 25) + s2 * (1 << 20) + s1 * (1 << 15) + f3 * (1 << 12) + d * (1 << 7) + 51;
        end else if (o == 4) begin
            w = im * (1 << 20) + s1 * (1 << 15) + d * (1 << 7) + 19;
        end else if (o == 5) begin
            w = im * (1 << 20) + s1 * (1 << 15) + 2 * (1 << 12) + d * (1 << 7) + 3;
        end else if (o == 6) begin
            w = (im / 32) * (1 << 25) + s2 * (1 << 20) + s1 * (1 << 15) + 2 * (1 << 12)
                + (im % 32) * (1 << 7) + 35;
        end
        return w;
    endfunction

    task automatic idle_inputs();
        start = 0; finish = 0; in_valid = 0;
        op = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    endtask

    task automatic open_session();
        start = 1;
        tick();
        start = 0;
        m_count = 0; m_addr = 32'h0; m_err = 0; m_done = 0;
        tests++;
        if (in_ready !== 1'b1 || count !== 16'd0 || done !== 1'b0 || err !== 1'b0
            || mem_addr !== 32'h0 || mem_write !== 1'b0) begin
            failed++;
            $display("FAIL start: in_ready=%b count=%0d done=%b err=%b addr=%h wr=%b, required 1 0 0 0 0 0",
                     in_ready, count, done, err, mem_addr, mem_write);
        end
    endtask

    // Presents one instruction for one cycle and checks the write (or error) that follows.
    task automatic send(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [11:0] im, input logic fin);
        logic [31:0] w;
        w = ref_enc(32'(o), 32'(d), 32'(s1), 32'(s2), 32'(im));
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1; finish = fin;
        tick();
        in_valid = 0; finish = 0;
        if (o == 3'd7) begin
            m_err  = 1;
            m_done = fin;
            tests++;
            if (mem_write !== 1'b0 || err !== 1'b1 || count !== 16'(m_count)
                || done !== m_done || in_ready !== !m_done) begin
                failed++;
                $display("FAIL illegal: wr=%b err=%b count=%0d done=%b rdy=%b, required 0 1 %0d %b %b",
                         mem_write, err, count, done, in_ready, m_count, m_done, !m_done);
            end
        end else begin
            tests++;
            if (mem_write !== 1'b1 || mem_addr !== m_addr || mem_wdata !== w || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL write op=%0d: wr=%b addr=%h data=%h rdy=%b, required 1 %h %h 0",
                         o, mem_write, mem_addr, mem_wdata, in_ready, m_addr, w);
            end
            tick();
            m_count++;
            m_addr = m_addr + 32'd4;
            m_done = fin || (m_count == MAXW);
            tests++;
            if (mem_write !== 1'b0 || count !== 16'(m_count) || mem_addr !== m_addr
                || done !== m_done || in_ready !== !m_done || err !== m_err) begin
                failed++;
                $display("FAIL post-write: wr=%b count=%0d addr=%h done=%b rdy=%b err=%b, required 0 %0d %h %b %b %b",
                         mem_write, count, mem_addr, done, in_ready, err, m_count, m_addr, m_done, !m_done, m_err);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        #12;
        tests++;
        if (in_ready !== 0 || mem_write !== 0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0
            || count !== 16'h0 || done !== 0 || err !== 0) begin
            failed++;
            $display("FAIL reset: rdy=%b wr=%b addr=%h data=%h count=%0d done=%b err=%b, required all 0",
                     in_ready, mem_write, mem_addr, mem_wdata, count, done, err);
        end
        @(negedge clk);
        reset = 1;
        tick();
        tests++;
        if (in_ready !== 0) begin
            failed++;
            $display("FAIL idle_ready: in_ready=%b required 0", in_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        open_session();
        op = 0; rd = 3; rs1 = 1; rs2 = 2; in_valid = 1;
        tick();
        in_valid = 0;
        tests++;
        if (mem_write !== 1'b1) begin
            failed++;
            $display("FAIL mid_write_setup: wr=%b required 1", mem_write);
        end
        #2 reset = 0;
        #1;
        tests++;
        if (in_ready !== 0 || mem_write !== 0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0
            || count !== 16'h0 || done !== 0 || err !== 0) begin
            failed++;
            $display("FAIL async_reset: rdy=%b wr=%b addr=%h data=%h count=%0d done=%b err=%b, required all 0",
                     in_ready, mem_write, mem_addr, mem_wdata, count, done, err);
        end
        #3 reset = 1;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (in_ready !== 0 || mem_write !== 0) begin
                failed++;
                $display("FAIL no_start_ready: rdy=%b wr=%b, required 0 0", in_ready, mem_write);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_directed_words();
        open_session();
        send(3'd0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        tests++;
        if (ref_enc(0, 3, 1, 2, 0) !== 32'h002081B3 || ref_enc(1, 5, 6, 7, 0) !== 32'h407302B3) begin
            failed++;
            $display("FAIL ref_model: R-type reference disagrees with known words");
        end
        send(3'd1, 5'd5, 5'd6, 5'd7, 12'd0, 1'b0);
        send(3'd4, 5'd1, 5'd0, 5'd0, 12'hFFF, 1'b0);
        send(3'd5, 5'd4, 5'd2, 5'd0, 12'd12, 1'b0);
        open_session();
        send(3'd6, 5'd0, 5'd1, 5'd2, 12'd8, 1'b0);
        send(3'd2, 5'd9, 5'd10, 5'd11, 12'd0, 1'b0);
        send(3'd3, 5'd31, 5'd17, 5'd4, 12'd0, 1'b1);
    endtask

    task automatic test_illegal_op();
        open_session();
        send(3'd7, 5'd1, 5'd2, 5'd3, 12'd4, 1'b0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        send(3'd7, 5'd0, 5'd0, 5'd0, 12'd0, 1'b1);
        open_session();
    endtask

    task automatic test_finish_with_accept();
        open_session();
        send(3'd0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
        in_valid = 1;
        tick();
        tick();
        in_valid = 0;
        tests++;
        if (done !== 1 || count !== 16'd1 || in_ready !== 0 || mem_write !== 0) begin
            failed++;
            $display("FAIL finish_hold: done=%b count=%0d rdy=%b wr=%b, required 1 1 0 0",
                     done, count, in_ready, mem_write);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[12];
        int nwr;
        open_session();
        nwr = 0;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 6)); rd = 5'($urandom); rs1 = 5'($urandom);
            rs2 = 5'($urandom); imm = 12'($urandom);
            words[i] = ref_enc(32'(op), 32'(rd), 32'(rs1), 32'(rs2), 32'(imm));
            in_valid = 1;
            tick();
            tests++;
            if ((i % 2 == 0) && (i < 8)) begin
                if (mem_write !== 1 || mem_addr !== 32'(4 * (i / 2)) || mem_wdata !== words[i]) begin
                    failed++;
                    $display("FAIL b2b_write%0d: wr=%b addr=%h data=%h, required 1 %h %h",
                             i, mem_write, mem_addr, mem_wdata, 32'(4 * (i / 2)), words[i]);
                end
            end else if (mem_write !== 0) begin
                failed++;
                $display("FAIL b2b_extra%0d: wr=%b required 0", i, mem_write);
            end
            if (mem_write === 1'b1) nwr++;
        end
        in_valid = 0;
        tests++;
        if (nwr != 4 || done !== 1 || count !== 16'd4 || in_ready !== 0) begin
            failed++;
            $display("FAIL b2b_end: writes=%0d done=%b count=%0d rdy=%b, required 4 1 4 0",
                     nwr, done, count, in_ready);
        end
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 30; s++) begin
            open_session();
            while (!m_done) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    start = ($urandom_range(0, 3) == 0);
                    tick();
                    start = 0;
                    tests++;
                    if (in_ready !== 1 || mem_write !== 0 || count !== 16'(m_count) || mem_addr !== m_addr) begin
                        failed++;
                        $display("FAIL gap: rdy=%b wr=%b count=%0d addr=%h, required 1 0 %0d %h",
                                 in_ready, mem_write, count, mem_addr, m_count, m_addr);
                    end
                end
                send(($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
                     5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
                     ($urandom_range(0, 7) == 0));
            end
            in_valid = 1;
            tick();
            in_valid = 0;
            tests++;
            if (done !== 1 || mem_write !== 0 || count !== 16'(m_count) || err !== m_err) begin
                failed++;
                $display("FAIL done_hold: done=%b wr=%b count=%0d err=%b, required 1 0 %0d %b",
                         done, mem_write, count, err, m_count, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_directed_words();
        test_illegal_op();
        test_finish_with_accept();
        test_back_to_back();
        test_random_sessions();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
